// File: rtl/epd_pkg.sv
// Shared constants, state encoding and latched-frame payload for the
// Ethernet packet generator (epg_fsm) and its byte counter.
package epd_pkg;

    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned LEN_W        = 11;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned ADDR_W       = 48;
    localparam int unsigned TYPE_W       = 16;

    localparam logic [BYTE_W-1:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [BYTE_W-1:0] SFD_BYTE      = 8'hD5;
    localparam logic [BYTE_W-1:0] IDLE_BYTE     = 8'h00;

    localparam int unsigned PREAMBLE_LEN = 7;
    localparam int unsigned ADDR_BYTES   = 6;
    localparam int unsigned TYPE_BYTES   = 2;
    localparam int unsigned MIN_PAYLOAD  = 46;
    localparam int unsigned MAX_PAYLOAD  = 1500;
    localparam int unsigned IFG_CYCLES   = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DST,
        ST_SRC,
        ST_TYPE,
        ST_PAYLOAD,
        ST_IFG
    } epg_state_e;

    // Header fields held for the whole frame; address/type are shifted out MSB first.
    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [ADDR_W-1:0] src;
        logic [TYPE_W-1:0] type_length;
        logic [LEN_W-1:0]  pay_len;
    } epg_frame_t;

    // Number of payload bytes actually fetched from the payload source.
    function automatic logic [LEN_W-1:0] real_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_PAYLOAD)) ? LEN_W'(MAX_PAYLOAD) : len;
    endfunction

    // Payload bytes put on the line, zero-padded up to the minimum frame size.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] rl);
        return (rl < LEN_W'(MIN_PAYLOAD)) ? LEN_W'(MIN_PAYLOAD) : rl;
    endfunction

endpackage

// File: rtl/epg_byte_cnt.sv
// Loadable down-counter used to time each frame field.
// Ports: clock/reset, load + load_val (load wins), dec (saturates at 0),
//        zero_c = counter currently at zero (combinational from the register).
module epg_byte_cnt
    import epd_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [LEN_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - LEN_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/epg_fsm.sv
// Ethernet frame generator: on start, emits preamble, SFD, DST, SRC, TYPE and
// a padded payload one byte per cycle, then a fixed inter-frame gap.
// Ports: clock, reset (async, active high); start, dst_addr, src_addr,
//        type_length, payload_len (latched on launch); payload_data/payload_rd
//        fetch handshake; data/control line outputs; busy; sent_packet_counter.
module epg_fsm
    import epd_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [TYPE_W-1:0] type_length,
    input  logic [LEN_W-1:0]  payload_len,
    input  logic [BYTE_W-1:0] payload_data,
    output logic              payload_rd,
    output logic [BYTE_W-1:0] data,
    output logic              control,
    output logic              busy,
    output logic [CNT_W-1:0]  sent_packet_counter
);

    epg_state_e        state, state_n;
    epg_frame_t        frame, frame_n;
    logic [LEN_W-1:0]  rd_left, rd_left_n;
    logic [BYTE_W-1:0] data_n;
    logic              control_n;
    logic              payload_rd_n;
    logic              busy_n;
    logic [CNT_W-1:0]  pkt_cnt_n;

    logic              cnt_load;
    logic [LEN_W-1:0]  cnt_load_val;
    logic              cnt_dec;
    logic              cnt_zero_c;
    logic              launch;

    epg_byte_cnt u_byte_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero_c   (cnt_zero_c)
    );

    // A held start re-launches straight out of the last gap cycle so the gap stays exact.
    assign launch = start && ((state == ST_IDLE) || ((state == ST_IFG) && cnt_zero_c));

    // Next-state and next-output logic; the counter holds bytes left after the current one.
    always_comb begin
        state_n      = state;
        frame_n      = frame;
        rd_left_n    = rd_left;
        data_n       = IDLE_BYTE;
        control_n    = 1'b0;
        payload_rd_n = 1'b0;
        pkt_cnt_n    = sent_packet_counter;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        case (state)
            ST_IDLE: begin
            end
            ST_PREAMBLE: begin
                control_n = 1'b1;
                if (cnt_zero_c) begin
                    state_n = ST_SFD;
                    data_n  = SFD_BYTE;
                end else begin
                    data_n  = PREAMBLE_BYTE;
                    cnt_dec = 1'b1;
                end
            end
            ST_SFD: begin
                control_n     = 1'b1;
                state_n       = ST_DST;
                data_n        = frame.dst[ADDR_W-1 -: BYTE_W];
                frame_n.dst   = {frame.dst[ADDR_W-BYTE_W-1:0], IDLE_BYTE};
                cnt_load      = 1'b1;
                cnt_load_val  = LEN_W'(ADDR_BYTES - 1);
            end
            ST_DST: begin
                control_n = 1'b1;
                if (cnt_zero_c) begin
                    state_n      = ST_SRC;
                    data_n       = frame.src[ADDR_W-1 -: BYTE_W];
                    frame_n.src  = {frame.src[ADDR_W-BYTE_W-1:0], IDLE_BYTE};
                    cnt_load     = 1'b1;
                    cnt_load_val = LEN_W'(ADDR_BYTES - 1);
                end else begin
                    data_n      = frame.dst[ADDR_W-1 -: BYTE_W];
                    frame_n.dst = {frame.dst[ADDR_W-BYTE_W-1:0], IDLE_BYTE};
                    cnt_dec     = 1'b1;
                end
            end
            ST_SRC: begin
                control_n = 1'b1;
                if (cnt_zero_c) begin
                    state_n             = ST_TYPE;
                    data_n              = frame.type_length[TYPE_W-1 -: BYTE_W];
                    frame_n.type_length = {frame.type_length[TYPE_W-BYTE_W-1:0], IDLE_BYTE};
                    cnt_load            = 1'b1;
                    cnt_load_val        = LEN_W'(TYPE_BYTES - 1);
                end else begin
                    data_n      = frame.src[ADDR_W-1 -: BYTE_W];
                    frame_n.src = {frame.src[ADDR_W-BYTE_W-1:0], IDLE_BYTE};
                    cnt_dec     = 1'b1;
                end
            end
            ST_TYPE: begin
                control_n = 1'b1;
                if (cnt_zero_c) begin
                    state_n      = ST_PAYLOAD;
                    data_n       = payload_rd ? payload_data : IDLE_BYTE;
                    cnt_load     = 1'b1;
                    cnt_load_val = frame.pay_len - LEN_W'(1);
                end else begin
                    data_n              = frame.type_length[TYPE_W-1 -: BYTE_W];
                    frame_n.type_length = {frame.type_length[TYPE_W-BYTE_W-1:0], IDLE_BYTE};
                    cnt_dec             = 1'b1;
                end
                // Fetch one cycle ahead of each real payload byte.
                if (rd_left != '0) begin
                    payload_rd_n = 1'b1;
                    rd_left_n    = rd_left - LEN_W'(1);
                end
            end
            ST_PAYLOAD: begin
                if (cnt_zero_c) begin
                    state_n      = ST_IFG;
                    pkt_cnt_n    = sent_packet_counter + CNT_W'(1);
                    cnt_load     = 1'b1;
                    cnt_load_val = LEN_W'(IFG_CYCLES - 1);
                end else begin
                    control_n = 1'b1;
                    data_n    = payload_rd ? payload_data : IDLE_BYTE;
                    cnt_dec   = 1'b1;
                    if (rd_left != '0) begin
                        payload_rd_n = 1'b1;
                        rd_left_n    = rd_left - LEN_W'(1);
                    end
                end
            end
            ST_IFG: begin
                if (cnt_zero_c) begin
                    state_n = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (launch) begin
            state_n             = ST_PREAMBLE;
            frame_n.dst         = dst_addr;
            frame_n.src         = src_addr;
            frame_n.type_length = type_length;
            frame_n.pay_len     = eff_len(real_len(payload_len));
            rd_left_n           = real_len(payload_len);
            data_n              = PREAMBLE_BYTE;
            control_n           = 1'b1;
            cnt_load            = 1'b1;
            cnt_load_val        = LEN_W'(PREAMBLE_LEN - 1);
            cnt_dec             = 1'b0;
        end

        busy_n = (state_n != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= ST_IDLE;
            frame               <= '0;
            rd_left             <= '0;
            data                <= IDLE_BYTE;
            control             <= 1'b0;
            payload_rd          <= 1'b0;
            busy                <= 1'b0;
            sent_packet_counter <= '0;
        end else begin
            state               <= state_n;
            frame               <= frame_n;
            rd_left             <= rd_left_n;
            data                <= data_n;
            control             <= control_n;
            payload_rd          <= payload_rd_n;
            busy                <= busy_n;
            sent_packet_counter <= pkt_cnt_n;
        end
    end

endmodule

// File: tb/tb_epg_fsm.sv
// Self-checking bench for epg_fsm: frames are captured from the line and
// compared against a byte list built from the frame format rules.
module tb_epg_fsm;

    logic        clock       = 1'b0;
    logic        reset       = 1'b0;
    logic        start       = 1'b0;
    logic [47:0] dst_addr    = '0;
    logic [47:0] src_addr    = '0;
    logic [15:0] type_length = '0;
    logic [10:0] payload_len = '0;
    logic [7:0]  payload_data;
    logic        payload_rd;
    logic [7:0]  data;
    logic        control;
    logic        busy;
    logic [3:0]  sent_packet_counter;

    int n_tests = 0;
    int n_fail  = 0;

    // Payload source: byte rd_idx is presented until a fetch consumes it.
    logic [7:0]  pay [0:4095];
    logic [11:0] rd_idx = '0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int rd_seen;
    int gap_len;
    int gap_bad;
    int mbase   = 0;
    int exp_cnt = 0;

    epg_fsm dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .dst_addr            (dst_addr),
        .src_addr            (src_addr),
        .type_length         (type_length),
        .payload_len         (payload_len),
        .payload_data        (payload_data),
        .payload_rd          (payload_rd),
        .data                (data),
        .control             (control),
        .busy                (busy),
        .sent_packet_counter (sent_packet_counter)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (payload_rd === 1'b1) rd_idx <= rd_idx + 12'd1;
    end

    assign payload_data = pay[rd_idx];

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int real_of(input int len);
        return (len > 1500) ? 1500 : len;
    endfunction

    // Reference frame: preamble, SFD, addresses and type MSB first, padded payload.
    function automatic void build_exp(input logic [47:0] d, input logic [47:0] s,
                                      input logic [15:0] t, input int len, input int base);
        int rl;
        int eff;
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) exp_q.push_back(d[8*i +: 8]);
        for (int i = 5; i >= 0; i--) exp_q.push_back(s[8*i +: 8]);
        exp_q.push_back(t[15:8]);
        exp_q.push_back(t[7:0]);
        rl  = real_of(len);
        eff = (rl < 46) ? 46 : rl;
        for (int i = 0; i < eff; i++)
            exp_q.push_back((i < rl) ? pay[(base + i) % 4096] : 8'h00);
    endfunction

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // Present fields and start at a falling edge; returns at the first byte sample.
    task automatic launch(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                          input int len, input bit hold);
        dst_addr    = d;
        src_addr    = s;
        type_length = t;
        payload_len = 11'(len);
        start       = 1'b1;
        @(negedge clock);
        if (!hold) begin
            start       = 1'b0;
            dst_addr    = 48'({$urandom(), $urandom()});
            src_addr    = 48'({$urandom(), $urandom()});
            type_length = 16'($urandom());
            payload_len = 11'($urandom());
        end
    endtask

    // Collect bytes while control is high; optionally pulse start mid-frame.
    task automatic grab_frame(input bit poke, output bit to);
        int cyc;
        int poke_at;
        cyc     = 0;
        poke_at = poke ? int'($urandom_range(1, 20)) : -5;
        to      = 1'b0;
        rd_seen = 0;
        got_q.delete();
        while (control === 1'b1) begin
            got_q.push_back(data);
            if (payload_rd === 1'b1) rd_seen++;
            if (cyc == poke_at) start = 1'b1;
            else if (cyc == poke_at + 1) start = 1'b0;
            @(negedge clock);
            cyc++;
            if (cyc > 2000) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    // Count gap cycles (busy, control low) until idle or the next frame.
    task automatic grab_gap(output bit to);
        gap_len = 0;
        gap_bad = 0;
        to      = 1'b0;
        while (control === 1'b0 && busy === 1'b1) begin
            if (data !== 8'h00 || payload_rd !== 1'b0) gap_bad++;
            gap_len++;
            @(negedge clock);
            if (gap_len > 40) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        n_tests++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data); end
        n_tests++; if (control !== 1'b0) begin n_fail++; $display("FAIL reset_control got %b want 0", control); end
        n_tests++; if (payload_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd got %b want 0", payload_rd); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (sent_packet_counter !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", sent_packet_counter); end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_tests++; if (control !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset control %b busy %b want 0 0", control, busy); end
        exp_cnt = 0;
    endtask

    task automatic test_nominal();
        bit to;
        int d;
        for (int k = 0; k < 4096; k++) pay[(mbase + k) % 4096] = 8'h55 + 8'(k % 5);
        build_exp(48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 50, mbase);
        launch(48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 50, 1'b0);
        grab_frame(1'b0, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL nominal_timeout frame never ended"); end
        n_tests++; if (got_q.size() != 72) begin n_fail++; $display("FAIL nominal_len got %0d want 72", got_q.size()); end
        d = first_diff();
        n_tests++; if (d >= 0) begin n_fail++; $display("FAIL nominal_bytes idx %0d got %h want %h", d, got_q[d], exp_q[d]); end
        n_tests++; if (rd_seen != 50) begin n_fail++; $display("FAIL nominal_rd got %0d want 50", rd_seen); end
        mbase += 50;
        exp_cnt = (exp_cnt + 1) % 16;
        n_tests++; if (sent_packet_counter !== 4'(exp_cnt)) begin n_fail++; $display("FAIL nominal_cnt_at_ifg got %0d want %0d", sent_packet_counter, exp_cnt); end
        grab_gap(to);
        n_tests++; if (to || gap_len != 12) begin n_fail++; $display("FAIL nominal_gap got %0d want 12", gap_len); end
        n_tests++; if (gap_bad != 0) begin n_fail++; $display("FAIL nominal_gap_data got %0d bad cycles want 0", gap_bad); end
        n_tests++; if (sent_packet_counter !== 4'd1) begin n_fail++; $display("FAIL nominal_cnt got %0d want 1", sent_packet_counter); end
    endtask

    // Short and oversize frames plus the clamp/pad boundaries.
    task automatic test_lengths();
        int lens[9];
        bit to;
        int d;
        logic [47:0] ds;
        logic [47:0] ss;
        logic [15:0] ts;
        lens = '{10, 2000, 0, 45, 46, 47, 1499, 1500, 1501};
        for (int k = 0; k < 4096; k++) pay[k] = 8'($urandom());
        foreach (lens[i]) begin
            ds = 48'({$urandom(), $urandom()});
            ss = 48'({$urandom(), $urandom()});
            ts = 16'($urandom());
            build_exp(ds, ss, ts, lens[i], mbase);
            launch(ds, ss, ts, lens[i], 1'b0);
            grab_frame(1'b1, to);
            n_tests++; if (to) begin n_fail++; $display("FAIL len%0d_timeout", lens[i]); end
            n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL len%0d_size got %0d want %0d", lens[i], got_q.size(), exp_q.size()); end
            d = first_diff();
            n_tests++; if (d >= 0) begin n_fail++; $display("FAIL len%0d_bytes idx %0d got %h want %h", lens[i], d, got_q[d], exp_q[d]); end
            n_tests++; if (rd_seen != real_of(lens[i])) begin n_fail++; $display("FAIL len%0d_rd got %0d want %0d", lens[i], rd_seen, real_of(lens[i])); end
            mbase += real_of(lens[i]);
            exp_cnt = (exp_cnt + 1) % 16;
            grab_gap(to);
            n_tests++; if (to || gap_len != 12 || gap_bad != 0) begin n_fail++; $display("FAIL len%0d_gap got %0d bad %0d want 12 0", lens[i], gap_len, gap_bad); end
            n_tests++; if (sent_packet_counter !== 4'(exp_cnt)) begin n_fail++; $display("FAIL len%0d_cnt got %0d want %0d", lens[i], sent_packet_counter, exp_cnt); end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int d;
        int len;
        logic [47:0] ds;
        logic [47:0] ss;
        logic [15:0] ts;
        ds  = 48'({$urandom(), $urandom()});
        ss  = 48'({$urandom(), $urandom()});
        ts  = 16'($urandom());
        len = int'($urandom_range(0, 80));
        launch(ds, ss, ts, len, 1'b1);
        for (int f = 0; f < 3; f++) begin
            if (f == 2) start = 1'b0;
            build_exp(ds, ss, ts, len, mbase);
            grab_frame(1'b0, to);
            n_tests++; if (to || got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b%0d_size got %0d want %0d", f, got_q.size(), exp_q.size()); end
            d = first_diff();
            n_tests++; if (d >= 0) begin n_fail++; $display("FAIL b2b%0d_bytes idx %0d got %h want %h", f, d, got_q[d], exp_q[d]); end
            mbase += real_of(len);
            exp_cnt = (exp_cnt + 1) % 16;
            grab_gap(to);
            n_tests++; if (to || gap_len != 12 || gap_bad != 0) begin n_fail++; $display("FAIL b2b%0d_gap got %0d bad %0d want 12 0", f, gap_len, gap_bad); end
        end
        n_tests++; if (busy !== 1'b0 || control !== 1'b0) begin n_fail++; $display("FAIL b2b_extra_frame busy %b control %b want 0 0", busy, control); end
        n_tests++; if (sent_packet_counter !== 4'(exp_cnt)) begin n_fail++; $display("FAIL b2b_cnt got %0d want %0d", sent_packet_counter, exp_cnt); end
    endtask

    task automatic test_mid_reset();
        bit to;
        int d;
        logic [47:0] ds;
        logic [47:0] ss;
        logic [15:0] ts;
        ds = 48'({$urandom(), $urandom()});
        ss = 48'({$urandom(), $urandom()});
        ts = 16'($urandom());
        launch(ds, ss, ts, 60, 1'b0);
        repeat (16) @(negedge clock);
        n_tests++; if (control !== 1'b1 || data !== ss[31:24]) begin n_fail++; $display("FAIL midrst_in_src control %b data %h want 1 %h", control, data, ss[31:24]); end
        reset = 1'b1;
        #1;
        n_tests++; if (control !== 1'b0 || data !== 8'h00) begin n_fail++; $display("FAIL midrst_line control %b data %h want 0 00", control, data); end
        n_tests++; if (busy !== 1'b0 || payload_rd !== 1'b0) begin n_fail++; $display("FAIL midrst_busy busy %b rd %b want 0 0", busy, payload_rd); end
        n_tests++; if (sent_packet_counter !== 4'd0) begin n_fail++; $display("FAIL midrst_cnt got %0d want 0", sent_packet_counter); end
        @(negedge clock);
        reset = 1'b0;
        exp_cnt = 0;
        @(negedge clock);
        ds = 48'({$urandom(), $urandom()});
        build_exp(ds, ss, ts, 60, mbase);
        launch(ds, ss, ts, 60, 1'b0);
        grab_frame(1'b0, to);
        n_tests++; if (to || got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midrst_next_size got %0d want %0d", got_q.size(), exp_q.size()); end
        d = first_diff();
        n_tests++; if (d >= 0) begin n_fail++; $display("FAIL midrst_next_bytes idx %0d got %h want %h", d, got_q[d], exp_q[d]); end
        mbase += 60;
        exp_cnt = (exp_cnt + 1) % 16;
        grab_gap(to);
        n_tests++; if (sent_packet_counter !== 4'd1) begin n_fail++; $display("FAIL midrst_next_cnt got %0d want 1", sent_packet_counter); end
    endtask

    task automatic test_wrap();
        bit to;
        int d;
        int len;
        int bad_frames;
        int idle_bad;
        logic [47:0] ds;
        logic [47:0] ss;
        logic [15:0] ts;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_cnt = 0;
        @(negedge clock);
        bad_frames = 0;
        for (int f = 0; f < 16; f++) begin
            ds  = 48'({$urandom(), $urandom()});
            ss  = 48'({$urandom(), $urandom()});
            ts  = 16'($urandom());
            len = int'($urandom_range(0, 60));
            build_exp(ds, ss, ts, len, mbase);
            launch(ds, ss, ts, len, 1'b0);
            grab_frame(1'b1, to);
            d = first_diff();
            if (to || d >= 0 || got_q.size() != exp_q.size() || rd_seen != len) bad_frames++;
            mbase += len;
            exp_cnt = (exp_cnt + 1) % 16;
            grab_gap(to);
            if (to || gap_len != 12 || gap_bad != 0) bad_frames++;
            if (f == 14) begin
                n_tests++; if (sent_packet_counter !== 4'd15) begin n_fail++; $display("FAIL wrap_cnt15 got %0d want 15", sent_packet_counter); end
            end
        end
        n_tests++; if (bad_frames != 0) begin n_fail++; $display("FAIL wrap_frames got %0d bad want 0", bad_frames); end
        n_tests++; if (sent_packet_counter !== 4'd0) begin n_fail++; $display("FAIL wrap_cnt got %0d want 0", sent_packet_counter); end
        idle_bad = 0;
        repeat (20) begin
            if (control !== 1'b0 || busy !== 1'b0) idle_bad++;
            @(negedge clock);
        end
        n_tests++; if (idle_bad != 0) begin n_fail++; $display("FAIL wrap_no_extra got %0d busy cycles want 0", idle_bad); end
    endtask

    initial begin
        for (int k = 0; k < 4096; k++) pay[k] = 8'h00;
        #1;
        test_reset();
        test_nominal();
        test_lengths();
        test_back_to_back();
        test_mid_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/epg_fsm.md
EPG_FSM -- requirements
Module: epg_fsm

Interface
REQ-001 SHALL have ports: clock  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: start  in  1  request to send one frame; sampled only in IDLE.
REQ-004 SHALL have: dst_addr  in  48  destination MAC; [47:40] sent first.
REQ-005 SHALL have: src_addr  in  48  source MAC; [47:40] sent first.
REQ-006 SHALL have: type_length  in  16  [15:8] sent first.
REQ-007 SHALL have: payload_len  in  11  payload byte count requested.
REQ-008 SHALL have: payload_data  in  8  payload byte, valid in any cycle where payload_rd=1.
REQ-009 SHALL have: payload_rd  out  1  fetch strobe, one cycle per consumed payload byte.
REQ-010 SHALL have: data  out  8  registered line byte.
REQ-011 SHALL have: control  out  1  registered; 1 = frame byte on data, 0 = idle/IFG.
REQ-012 SHALL have: busy  out  1  high in every state except IDLE.
REQ-013 SHALL have: sent_packet_counter  out  4  completed frames, wraps 15->0.

Function
REQ-014 SHALL implement states IDLE, PREAMBLE, SFD, DST, SRC, TYPE, PAYLOAD, IFG.
REQ-015 In IDLE, start=1 at an edge SHALL latch dst_addr, src_addr, type_length and payload_len, and enter PREAMBLE; data=8'h55/control=1 SHALL appear after that same edge.
REQ-016 Sequence, one byte per cycle, control=1: 7x 8'h55, 1x 8'hD5, 6 DST bytes, 6 SRC bytes, 2 TYPE bytes, then payload.
REQ-017 Effective payload length SHALL be max(46, min(payload_len, 1500)).
REQ-018 payload_rd SHALL be high in the cycle before each real payload byte is output, for min(payload_len, 1500) bytes.
REQ-019 payload_data SHALL be sampled at that edge and driven on data after it.
REQ-020 If payload_len < 46, bytes beyond payload_len SHALL be 8'h00, with payload_rd=0.
REQ-021 After the last payload byte, the block SHALL enter IFG for exactly 12 cycles with control=0 and data=8'h00, then return to IDLE.
REQ-022 sent_packet_counter SHALL increment at the edge leaving PAYLOAD.
REQ-023 In IDLE, outputs SHALL be control=0, data=8'h00, payload_rd=0.
REQ-024 start while busy=1 SHALL be ignored and not queued.
REQ-025 start held high SHALL begin the next frame on the first edge in IDLE after IFG, giving back-to-back frames separated by exactly 12 IFG cycles.
REQ-026 Latched fields SHALL NOT change mid-frame when the inputs change.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, data=8'h00, control=0, payload_rd=0, busy=0 and sent_packet_counter=0, including mid-frame.
REQ-028 An aborted frame SHALL NOT be counted; after reset release the first start SHALL begin a fresh preamble.

Structure
REQ-029 Shared package epd_pkg SHALL hold: PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, MIN_PAYLOAD=46, MAX_PAYLOAD=1500, IFG_CYCLES=12, and the state encoding typedef.
REQ-030 A single sub-module epg_byte_cnt (loadable 11-bit down-counter with zero flag) SHALL provide per-field byte counting.
REQ-031 No other sub-modules are required.

Verification
REQ-032 Nominal frame: dst=01..06, src=FF..FA, type=0800, len=50, payload 55..59 repeating -> 72 control=1 cycles, byte-exact; 50 payload_rd pulses; then 12 IFG cycles; counter=1.
REQ-033 Short frame: len=10 -> 10 payload_rd pulses, then 36 bytes of 8'h00; 68 control=1 cycles total.
REQ-034 Oversize frame: len=2000 -> exactly 1500 payload bytes and 1500 payload_rd pulses.
REQ-035 Back-to-back: start held high for 3 frames -> 3 frames, each gap exactly 12 cycles of control=0/data=00; counter=3.
REQ-036 Mid-frame reset during SRC -> control=0 and data=00 immediately; counter unchanged at 0; next frame is correct from preamble.
REQ-037 Wrap: send 16 frames -> counter reads 0; start pulses during busy produce no extra frames.
REQ-038 Loopback: feed data/control into the existing epd_fsm receiver -> all its valid outputs assert for each frame.
